// File: rtl/vending_machinef.sv
// Coin-operated vending controller for a single 15 rs item.
// Tracks 0/5/10 rs credit, dispenses, returns change, refunds on idle timeout.
module vending_machinef #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic [1:0] out,
    output logic [1:0] change,
    output logic [2:0] state_led
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] S5   = 2'd1;
    localparam logic [1:0] S10  = 2'd2;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam logic [CW-1:0] CNT_LIM = CW'(TLIM);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    state_q, state_d;
    logic [1:0]    out_q, out_d;
    logic [1:0]    change_q, change_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        out_d    = 2'b00;
        change_d = 2'b00;
        cnt_d    = cnt_q;
        case (in)
            COIN_5: begin
                cnt_d = '0;
                case (state_q)
                    IDLE:    state_d = S5;
                    S5:      state_d = S10;
                    S10: begin
                        state_d = IDLE;
                        out_d   = 2'b01;
                    end
                    default: state_d = IDLE;
                endcase
            end
            COIN_10: begin
                cnt_d = '0;
                case (state_q)
                    IDLE:    state_d = S10;
                    S5: begin
                        state_d = IDLE;
                        out_d   = 2'b01;
                    end
                    S10: begin
                        state_d  = IDLE;
                        out_d    = 2'b01;
                        change_d = 2'b01;
                    end
                    default: state_d = IDLE;
                endcase
            end
            COIN_NONE: begin
                // refund fires on the edge the count would reach TIMEOUT
                if (TIMEOUT > 0 && state_q != IDLE) begin
                    if (cnt_q == CNT_LIM) begin
                        state_d  = IDLE;
                        change_d = (state_q == S10) ? 2'b10 : 2'b01;
                        cnt_d    = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: out_d = 2'b10;
        endcase
        if (state_d == IDLE) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= 2'b00;
            change_q <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            change_q <= change_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out    = out_q;
    assign change = change_q;

    always_comb begin
        state_led = 3'b001;
        case (state_q)
            S5:      state_led = 3'b010;
            S10:     state_led = 3'b100;
            default: state_led = 3'b001;
        endcase
    end

endmodule

// File: tb/tb_vending_machinef.sv
// Directed bench for vending_machinef with hand-computed expectations.
module tb_vending_machinef;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic [1:0] out;
    logic [1:0] change;
    logic [2:0] state_led;

    int total = 0;
    int bad   = 0;

    vending_machinef #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .in(in),
        .out(out),
        .change(change),
        .state_led(state_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [1:0] c);
        @(negedge clk);
        in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] eo,
                       input logic [1:0] ec, input logic [2:0] el);
        total++;
        assert (out === eo) else begin
            bad++;
            $error("FAIL %s out got=%b exp=%b", tag, out, eo);
        end
        total++;
        assert (change === ec) else begin
            bad++;
            $error("FAIL %s change got=%b exp=%b", tag, change, ec);
        end
        total++;
        assert (state_led === el) else begin
            bad++;
            $error("FAIL %s led got=%b exp=%b", tag, state_led, el);
        end
    endtask

    initial begin
        rst = 1'b1;
        in  = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset", 2'b00, 2'b00, 3'b001);
        @(negedge clk);
        rst = 1'b0;

        step(2'b01); chk("t2_5", 2'b00, 2'b00, 3'b010);
        step(2'b10); chk("t2_15", 2'b01, 2'b00, 3'b001);
        step(2'b00); chk("t2_pulse", 2'b00, 2'b00, 3'b001);

        step(2'b11); chk("t3_inv_idle", 2'b10, 2'b00, 3'b001);
        step(2'b01); chk("t3_5", 2'b00, 2'b00, 3'b010);
        step(2'b11); chk("t3_inv_s5", 2'b10, 2'b00, 3'b010);
        step(2'b00); chk("t3_hold", 2'b00, 2'b00, 3'b010);
        step(2'b01); chk("t3_10", 2'b00, 2'b00, 3'b100);
        step(2'b01); chk("t3_15", 2'b01, 2'b00, 3'b001);

        step(2'b10); chk("t4_10", 2'b00, 2'b00, 3'b100);
        step(2'b10); chk("t4_20", 2'b01, 2'b01, 3'b001);

        step(2'b01); chk("t5a_coin", 2'b00, 2'b00, 3'b010);
        for (int i = 0; i < 15; i++) step(2'b00);
        chk("t5a_e15", 2'b00, 2'b00, 3'b010);
        step(2'b00); chk("t5a_e16", 2'b00, 2'b01, 3'b001);
        step(2'b00); chk("t5a_after", 2'b00, 2'b00, 3'b001);

        step(2'b10); chk("t5b_coin", 2'b00, 2'b00, 3'b100);
        for (int i = 0; i < 15; i++) step(2'b00);
        chk("t5b_e15", 2'b00, 2'b00, 3'b100);
        step(2'b00); chk("t5b_e16", 2'b00, 2'b10, 3'b001);

        step(2'b01); chk("t5c_coin", 2'b00, 2'b00, 3'b010);
        for (int i = 0; i < 14; i++) step(2'b00);
        step(2'b01); chk("t5c_e15coin", 2'b00, 2'b00, 3'b100);
        for (int i = 0; i < 15; i++) step(2'b00);
        chk("t5c_e15", 2'b00, 2'b00, 3'b100);
        step(2'b00); chk("t5c_e16", 2'b00, 2'b10, 3'b001);

        step(2'b10); chk("t6_10", 2'b00, 2'b00, 3'b100);
        in = 2'b00;
        #2 rst = 1'b1;
        #1 chk("t6_rst_mid", 2'b00, 2'b00, 3'b001);
        @(posedge clk);
        #1 chk("t6_rst_edge", 2'b00, 2'b00, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        step(2'b00); chk("t6_norefund", 2'b00, 2'b00, 3'b001);
        step(2'b10); chk("t6_hold1", 2'b00, 2'b00, 3'b100);
        step(2'b10); chk("t6_hold2", 2'b01, 2'b01, 3'b001);
        #2 rst = 1'b1;
        #1 chk("t6_rst_clear", 2'b00, 2'b00, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        in  = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
